// File: rtl/tdm_demux_1_2.sv
// Receive side of a 2:1 TDM link: locks on frame_sync (slot A) and splits the
// interleaved stream into registered A/B channels. Optional error counter: TDM_ERR_CNT_EN.
module tdm_demux_1_2 #(
    parameter int WIDTH     = 8,
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic [WIDTH-1:0]     din,
    input  logic                 din_valid,
    input  logic                 frame_sync,
    output logic [WIDTH-1:0]     a_out,
    output logic                 a_valid,
    output logic [WIDTH-1:0]     b_out,
    output logic                 b_valid,
    output logic                 pair_valid,
    output logic                 locked,
    output logic                 sync_err
`ifdef TDM_ERR_CNT_EN
    ,
    output logic [ERR_CNT_W-1:0] err_count
`endif
);

    // state    | meaning
    // HUNT     | not locked, waiting for a word with frame_sync
    // EXPECT_B | slot A captured, next word should be slot B
    // EXPECT_A | pair complete, next word should be slot A
    typedef enum logic [1:0] {
        HUNT     = 2'd0,
        EXPECT_B = 2'd1,
        EXPECT_A = 2'd2
    } state_t;

    state_t state, next_state;
    logic   cap_a, cap_b, err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= HUNT;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        cap_a      = 1'b0;
        cap_b      = 1'b0;
        err        = 1'b0;
        if (flush) begin
            next_state = HUNT;
        end else if (din_valid) begin
            unique case (state)
                HUNT: begin
                    if (frame_sync) begin
                        cap_a      = 1'b1;
                        next_state = EXPECT_B;
                    end
                end
                EXPECT_B: begin
                    // An early frame_sync restarts the pair with this word as the new A
                    if (frame_sync) begin
                        err   = 1'b1;
                        cap_a = 1'b1;
                    end else begin
                        cap_b      = 1'b1;
                        next_state = EXPECT_A;
                    end
                end
                EXPECT_A: begin
                    if (frame_sync) begin
                        cap_a      = 1'b1;
                        next_state = EXPECT_B;
                    end else begin
                        err        = 1'b1;
                        next_state = HUNT;
                    end
                end
                default: next_state = HUNT;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_out      <= '0;
            b_out      <= '0;
            a_valid    <= 1'b0;
            b_valid    <= 1'b0;
            pair_valid <= 1'b0;
            sync_err   <= 1'b0;
        end else begin
            a_valid    <= cap_a;
            b_valid    <= cap_b;
            pair_valid <= cap_b;
            sync_err   <= err;
            if (cap_a) a_out <= din;
            if (cap_b) b_out <= din;
        end
    end

    assign locked = (state == EXPECT_A) || (state == EXPECT_B);

`ifdef TDM_ERR_CNT_EN
    // Saturating; flush deliberately leaves the history intact
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                     err_count <= '0;
        else if (err && err_count != '1) err_count <= err_count + 1'b1;
    end
`endif

endmodule

// File: tb/tb_tdm_demux_1_2.sv
// Directed, table-driven bench for tdm_demux_1_2; also checks err_count when
// built with TDM_ERR_CNT_EN (counter width 2 to reach saturation quickly).
module tb_tdm_demux_1_2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       flush;
    logic [7:0] din;
    logic       din_valid;
    logic       frame_sync;
    logic [7:0] a_out;
    logic       a_valid;
    logic [7:0] b_out;
    logic       b_valid;
    logic       pair_valid;
    logic       locked;
    logic       sync_err;
`ifdef TDM_ERR_CNT_EN
    logic [1:0] err_count;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    tdm_demux_1_2 #(.WIDTH(8), .ERR_CNT_W(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .din        (din),
        .din_valid  (din_valid),
        .frame_sync (frame_sync),
        .a_out      (a_out),
        .a_valid    (a_valid),
        .b_out      (b_out),
        .b_valid    (b_valid),
        .pair_valid (pair_valid),
        .locked     (locked),
        .sync_err   (sync_err)
`ifdef TDM_ERR_CNT_EN
        ,
        .err_count  (err_count)
`endif
    );

    typedef struct {
        logic       fl;
        logic       dv;
        logic       fs;
        logic [7:0] d;
        logic [7:0] ea;
        logic       eav;
        logic [7:0] eb;
        logic       ebv;
        logic       epv;
        logic       elk;
        logic       ese;
        int         ec;
    } vec_t;

    vec_t vecs[20];

    function automatic vec_t mk(logic fl, logic dv, logic fs, logic [7:0] d,
                                logic [7:0] ea, logic eav, logic [7:0] eb, logic ebv,
                                logic epv, logic elk, logic ese, int ec);
        vec_t v;
        v.fl = fl; v.dv = dv; v.fs = fs; v.d = d;
        v.ea = ea; v.eav = eav; v.eb = eb; v.ebv = ebv;
        v.epv = epv; v.elk = elk; v.ese = ese; v.ec = ec;
        return v;
    endfunction

    task automatic chk(string name, int idx, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s step %0d: got %0h, expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic chk_outs(int idx, vec_t v);
        chk("a_out",      idx, 32'(a_out),      32'(v.ea));
        chk("a_valid",    idx, 32'(a_valid),    32'(v.eav));
        chk("b_out",      idx, 32'(b_out),      32'(v.eb));
        chk("b_valid",    idx, 32'(b_valid),    32'(v.ebv));
        chk("pair_valid", idx, 32'(pair_valid), 32'(v.epv));
        chk("locked",     idx, 32'(locked),     32'(v.elk));
        chk("sync_err",   idx, 32'(sync_err),   32'(v.ese));
`ifdef TDM_ERR_CNT_EN
        chk("err_count",  idx, 32'(err_count),  32'(v.ec));
`endif
    endtask

    // Drive, take one rising edge, check 1 time unit later.
    task automatic apply(int idx, vec_t v);
        flush      = v.fl;
        din_valid  = v.dv;
        frame_sync = v.fs;
        din        = v.d;
        @(posedge clk);
        #1;
        chk_outs(idx, v);
    endtask

    initial begin
        // fl dv fs din   a_out av b_out bv pv lk se ec
        vecs[0]  = mk(0, 1, 1, 8'h11, 8'h11, 1, 8'h00, 0, 0, 1, 0, 0);
        vecs[1]  = mk(0, 1, 0, 8'h22, 8'h11, 0, 8'h22, 1, 1, 1, 0, 0);
        vecs[2]  = mk(0, 1, 1, 8'h33, 8'h33, 1, 8'h22, 0, 0, 1, 0, 0);
        vecs[3]  = mk(0, 1, 0, 8'h44, 8'h33, 0, 8'h44, 1, 1, 1, 0, 0);
        vecs[4]  = mk(0, 1, 1, 8'h55, 8'h55, 1, 8'h44, 0, 0, 1, 0, 0);
        vecs[5]  = mk(0, 1, 1, 8'h77, 8'h77, 1, 8'h44, 0, 0, 1, 1, 1);
        vecs[6]  = mk(0, 1, 0, 8'h88, 8'h77, 0, 8'h88, 1, 1, 1, 0, 1);
        vecs[7]  = mk(0, 1, 0, 8'h99, 8'h77, 0, 8'h88, 0, 0, 0, 1, 2);
        vecs[8]  = mk(0, 1, 0, 8'hAA, 8'h77, 0, 8'h88, 0, 0, 0, 0, 2);
        vecs[9]  = mk(0, 1, 0, 8'hBB, 8'h77, 0, 8'h88, 0, 0, 0, 0, 2);
        vecs[10] = mk(0, 1, 1, 8'h5A, 8'h5A, 1, 8'h88, 0, 0, 1, 0, 2);
        vecs[11] = mk(0, 0, 1, 8'hEE, 8'h5A, 0, 8'h88, 0, 0, 1, 0, 2);
        vecs[12] = mk(0, 0, 0, 8'hEE, 8'h5A, 0, 8'h88, 0, 0, 1, 0, 2);
        vecs[13] = mk(0, 0, 1, 8'hEE, 8'h5A, 0, 8'h88, 0, 0, 1, 0, 2);
        vecs[14] = mk(0, 1, 0, 8'hC3, 8'h5A, 0, 8'hC3, 1, 1, 1, 0, 2);
        vecs[15] = mk(0, 1, 1, 8'hD4, 8'hD4, 1, 8'hC3, 0, 0, 1, 0, 2);
        vecs[16] = mk(1, 1, 1, 8'hE5, 8'hD4, 0, 8'hC3, 0, 0, 0, 0, 2);
        vecs[17] = mk(0, 1, 0, 8'hF6, 8'hD4, 0, 8'hC3, 0, 0, 0, 0, 2);
        vecs[18] = mk(0, 0, 1, 8'h12, 8'hD4, 0, 8'hC3, 0, 0, 0, 0, 2);
        vecs[19] = mk(0, 1, 1, 8'h12, 8'h12, 1, 8'hC3, 0, 0, 1, 0, 2);

        rst_n      = 1'b0;
        flush      = 1'b0;
        din_valid  = 1'b0;
        frame_sync = 1'b0;
        din        = 8'h00;
        #12;
        chk_outs(-1, mk(0, 0, 0, 8'h00, 8'h00, 0, 8'h00, 0, 0, 0, 0, 0));
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 20; i++) apply(i, vecs[i]);

        // Async reset while in EXPECT_B: outputs clear without a clock edge,
        // and the B word that follows is dropped as a broken pair.
        #3;
        rst_n = 1'b0;
        #1;
        chk_outs(100, mk(0, 0, 0, 8'h00, 8'h00, 0, 8'h00, 0, 0, 0, 0, 0));
        @(negedge clk);
        rst_n = 1'b1;
        apply(101, mk(0, 1, 0, 8'h66, 8'h00, 0, 8'h00, 0, 0, 0, 0, 0));

`ifdef TDM_ERR_CNT_EN
        apply(200, mk(0, 1, 1, 8'h01, 8'h01, 1, 8'h00, 0, 0, 1, 0, 0));
        for (int k = 0; k < 5; k++) begin
            logic [7:0] d;
            d = 8'(k + 2);
            apply(201 + k, mk(0, 1, 1, d, d, 1, 8'h00, 0, 0, 1, 1, (k < 3) ? k + 1 : 3));
        end
        apply(206, mk(1, 1, 1, 8'hFF, 8'h06, 0, 8'h00, 0, 0, 0, 0, 3));
        apply(207, mk(0, 1, 1, 8'h31, 8'h31, 1, 8'h00, 0, 0, 1, 0, 3));
        #3;
        rst_n = 1'b0;
        #1;
        chk_outs(208, mk(0, 0, 0, 8'h00, 8'h00, 0, 8'h00, 0, 0, 0, 0, 0));
        @(negedge clk);
        rst_n = 1'b1;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
